// File: rtl/hovalaag_bus_master.sv
// Host-side initiator for the Hovalaag wrapper's one-hot slot bus: serialises one
// instruction step (operands, instruction, execute), then reads back status/PC/OUT.
module hovalaag_bus_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_instr,
  input  logic [11:0] cmd_in1,
  input  logic [11:0] cmd_in2,
  input  logic        cmd_keep_inputs,
  output logic [9:0]  bus_addr,
  output logic [5:0]  bus_data,
  input  logic [7:0]  bus_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_in1_adv,
  output logic        rsp_in2_adv,
  output logic        rsp_out1_valid,
  output logic        rsp_out2_valid,
  output logic [7:0]  rsp_pc,
  output logic [11:0] rsp_out
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_READ, S_CAPT, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, w_idx_nxt, w_start_idx;
  logic [1:0]  r_rd, w_rd_nxt;
  logic        r_ready;
  logic [9:0]  r_addr, w_addr_nxt;
  logic [5:0]  r_data, w_data_nxt;
  logic [31:0] r_instr;
  logic [11:0] r_in1, r_in2, w_src_in1, w_src_in2;
  logic [3:0]  r_status;
  logic [7:0]  r_pc;
  logic [11:0] r_out;
  logic        r_rsp_valid;
  logic        w_fire;

  // LOAD walks idx 0..8: idx 0..3 are slots 6..9 (operands), idx 4..8 are slots 0..4.
  function automatic logic [9:0] load_slot(input logic [3:0] idx);
    logic [3:0] slot;
    slot = (idx < 4'd4) ? 4'(idx + 4'd6) : 4'(idx - 4'd4);
    return 10'(10'd1 << slot);
  endfunction

  function automatic logic [5:0] load_data(input logic [3:0] idx, input logic [31:0] instr,
                                           input logic [11:0] in1, input logic [11:0] in2);
    case (idx)
      4'd0:    return in1[5:0];
      4'd1:    return in1[11:6];
      4'd2:    return in2[5:0];
      4'd3:    return in2[11:6];
      4'd4:    return instr[5:0];
      4'd5:    return instr[11:6];
      4'd6:    return instr[17:12];
      4'd7:    return instr[23:18];
      default: return instr[29:24];
    endcase
  endfunction

  assign w_fire      = cmd_valid && r_ready;
  assign w_start_idx = cmd_keep_inputs ? 4'd4 : 4'd0;
  // The first LOAD word is launched in the handshake cycle, before the registers hold it.
  assign w_src_in1   = cmd_keep_inputs ? r_in1 : cmd_in1;
  assign w_src_in2   = cmd_keep_inputs ? r_in2 : cmd_in2;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rd_nxt    = r_rd;
    w_addr_nxt  = '0;
    w_data_nxt  = '0;
    case (r_state)
      S_IDLE: if (w_fire) begin
        w_state_nxt = S_LOAD;
        w_idx_nxt   = w_start_idx;
        w_addr_nxt  = load_slot(w_start_idx);
        w_data_nxt  = load_data(w_start_idx, cmd_instr, w_src_in1, w_src_in2);
      end
      S_LOAD: begin
        if (r_idx == 4'd8) begin
          w_state_nxt = S_EXEC;
          w_addr_nxt  = 10'h020;
          w_data_nxt  = {4'b0, r_instr[31:30]};
        end else begin
          w_idx_nxt   = 4'(r_idx + 4'd1);
          w_addr_nxt  = load_slot(w_idx_nxt);
          w_data_nxt  = load_data(w_idx_nxt, r_instr, r_in1, r_in2);
        end
      end
      S_EXEC: begin
        w_state_nxt = S_READ;
        w_rd_nxt    = 2'd0;
        w_addr_nxt  = 10'h040;
        w_data_nxt  = r_in1[5:0];
      end
      S_READ: begin
        // Read slots rewrite the shadowed operand values, so the wrapper inputs stay put.
        case (r_rd)
          2'd0: begin
            w_rd_nxt   = 2'd1;
            w_addr_nxt = 10'h080;
            w_data_nxt = r_in1[11:6];
          end
          2'd1: begin
            w_rd_nxt   = 2'd2;
            w_addr_nxt = 10'h100;
            w_data_nxt = r_in2[5:0];
          end
          default: w_state_nxt = S_CAPT;
        endcase
      end
      S_CAPT: w_state_nxt = S_RESP;
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_rd        <= '0;
      r_ready     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_instr     <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_status    <= '0;
      r_pc        <= '0;
      r_out       <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rd    <= w_rd_nxt;
      r_ready <= (w_state_nxt == S_IDLE);
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      if (w_fire) begin
        r_instr <= cmd_instr;
        if (!cmd_keep_inputs) begin
          r_in1 <= cmd_in1;
          r_in2 <= cmd_in2;
        end
      end
      if (r_state == S_READ) begin
        case (r_rd)
          2'd0:    r_status   <= bus_rdata[3:0];
          2'd1:    r_pc       <= bus_rdata;
          default: r_out[7:0] <= bus_rdata;
        endcase
      end
      if (r_state == S_CAPT) begin
        r_out[11:8] <= bus_rdata[3:0];
        r_rsp_valid <= 1'b1;
      end
      if (r_state == S_RESP && rsp_ready) r_rsp_valid <= 1'b0;
    end
  end

  assign cmd_ready      = r_ready;
  assign bus_addr       = r_addr;
  assign bus_data       = r_data;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_in1_adv    = r_status[0];
  assign rsp_in2_adv    = r_status[1];
  assign rsp_out1_valid = r_status[2];
  assign rsp_out2_valid = r_status[3];
  assign rsp_pc         = r_pc;
  assign rsp_out        = r_out;

endmodule
